// File: rtl/branch_unit.sv
// Branch condition resolution plus a PC-indexed table of 2-bit counters.
// Define BRANCH_UNIT_BYPASS_EN to forward same-index updates to predictions.
module branch_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BHT_ENTRIES = 16,
  parameter int PC_SHIFT    = 2,
  parameter int PERF_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_pred_valid,
  input  logic [ADDR_WIDTH-1:0] i_pred_pc,
  output logic                  o_pred_valid,
  output logic                  o_pred_taken,
  input  logic                  i_res_valid,
  input  logic [ADDR_WIDTH-1:0] i_res_pc,
  input  logic [2:0]            i_res_type,
  input  logic                  i_flag_zero,
  input  logic                  i_flag_sign,
  input  logic                  i_flag_overflow,
  input  logic                  i_flag_carry,
  input  logic                  i_res_pred_taken,
  output logic                  o_res_valid,
  output logic                  o_res_taken,
  output logic                  o_mispredict,
  output logic [PERF_WIDTH-1:0] o_mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BGE  = 3'd2,
    BR_BGEU = 3'd3,
    BR_BLT  = 3'd4,
    BR_BLTU = 3'd5,
    BR_BAL  = 3'd6,
    BR_RSV  = 3'd7
  } br_t;

  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];

  logic                  pred_valid_q, pred_valid_d;
  logic                  pred_taken_q, pred_taken_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_taken_q, res_taken_d;
  logic                  misp_q, misp_d;
  logic [PERF_WIDTH-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] ridx;
  logic             cond_taken;
  logic             cond_ok;
  logic             res_upd;
  logic             misp_now;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  logic [1:0]       pred_ctr;
  logic             unused_pc;

  assign pidx = i_pred_pc[IDX_W+PC_SHIFT-1:PC_SHIFT];
  assign ridx = i_res_pc[IDX_W+PC_SHIFT-1:PC_SHIFT];
  assign unused_pc = ^{i_pred_pc, i_res_pc};

  always_comb begin
    cond_taken = 1'b0;
    cond_ok    = 1'b1;
    unique case (br_t'(i_res_type))
      BR_BEQ:  cond_taken = i_flag_zero;
      BR_BNE:  cond_taken = ~i_flag_zero;
      BR_BGE:  cond_taken = (i_flag_sign == i_flag_overflow);
      BR_BGEU: cond_taken = i_flag_carry;
      BR_BLT:  cond_taken = (i_flag_sign != i_flag_overflow);
      BR_BLTU: cond_taken = ~i_flag_carry;
      BR_BAL:  cond_taken = 1'b1;
      default: begin
        cond_taken = 1'b0;
        cond_ok    = 1'b0;
      end
    endcase
  end

  // Retired branches train the table even when flushed.
  assign res_upd  = i_res_valid & cond_ok;
  assign misp_now = cond_taken ^ i_res_pred_taken;
  assign ctr_cur  = bht_q[ridx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (cond_taken) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (res_upd) bht_d[ridx] = ctr_nxt;
  end

  always_comb begin
    pred_ctr = bht_q[pidx];
`ifdef BRANCH_UNIT_BYPASS_EN
    if (res_upd && (ridx == pidx)) pred_ctr = ctr_nxt;
`endif
  end

  always_comb begin
    pred_valid_d = i_pred_valid & ~i_flush;
    pred_taken_d = pred_valid_d ? pred_ctr[1] : pred_taken_q;
    res_valid_d  = i_res_valid & ~i_flush;
    res_taken_d  = res_valid_d ? cond_taken : res_taken_q;
    misp_d       = res_valid_d ? misp_now : misp_q;
    cnt_d        = cnt_q;
    if (res_upd && misp_now && (cnt_q != {PERF_WIDTH{1'b1}}))
      cnt_d = cnt_q + PERF_WIDTH'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_taken_q  <= 1'b0;
      misp_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      res_valid_q  <= res_valid_d;
      res_taken_q  <= res_taken_d;
      misp_q       <= misp_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_pred_valid       = pred_valid_q;
  assign o_pred_taken       = pred_taken_q;
  assign o_res_valid        = res_valid_q;
  assign o_res_taken        = res_taken_q;
  assign o_mispredict       = misp_q;
  assign o_mispredict_count = cnt_q;

endmodule
